// File: rtl/until_checker.sv
`default_nettype none
// ============================================================================
// Module      : until_checker
// Description : Run-time checker for "p until q" (weak) or "p s_until q"
//               (strong). One attempt at a time, launched by start. eot
//               resolves a pending attempt. A MAX_WAIT timeout is optional.
//               Pass and fail are reported as registered one-cycle pulses and
//               counted by saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module until_checker #(
    parameter int STRONG   = 0,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             p,
    input  logic             q,
    input  logic             eot,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] wait_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [1:0]       c_code_none  = 2'b00;
    localparam logic [1:0]       c_code_pdrop = 2'b01;
    localparam logic [1:0]       c_code_eot   = 2'b10;
    localparam logic [1:0]       c_code_tmo   = 2'b11;
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_max_wait   = CNT_W'(MAX_WAIT);
    localparam bit               c_bounded    = (MAX_WAIT > 0);
    localparam bit               c_strong     = (STRONG != 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_pass;
    logic             w_fail;
    logic [1:0]       w_code;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_inc;
    logic [CNT_W-1:0] w_wait_nxt;

    assign busy = (r_state == S_WAIT);

    // Evaluate the until rule on every evaluation edge (start in IDLE, any
    // edge in WAIT), in priority order q, !p, eot, timeout, keep waiting.
    always_comb begin
        w_state_nxt = r_state;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_code      = c_code_none;
        w_wait_nxt  = wait_cnt;
        // A fresh attempt counts from zero; an ongoing one from the held count.
        w_base      = (r_state == S_IDLE) ? '0 : wait_cnt;
        w_inc       = w_base + c_one;
        if ((r_state == S_WAIT) || start) begin
            w_wait_nxt  = w_base;
            w_state_nxt = S_IDLE;
            if (q) begin
                w_pass = 1'b1;
            end else if (!p) begin
                w_fail = 1'b1;
                w_code = c_code_pdrop;
            end else if (eot) begin
                if (c_strong) begin
                    w_fail = 1'b1;
                    w_code = c_code_eot;
                end else begin
                    w_pass = 1'b1;
                end
            end else if (c_bounded && (w_inc == c_max_wait)) begin
                w_fail = 1'b1;
                w_code = c_code_tmo;
            end else begin
                w_wait_nxt  = w_inc;
                w_state_nxt = S_WAIT;
            end
        end
    end

    // State, registered verdict pulses and saturating pass/fail counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= c_code_none;
            wait_cnt  <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            pass      <= w_pass;
            fail      <= w_fail;
            fail_code <= w_code;
            wait_cnt  <= w_wait_nxt;
            if (w_pass && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + c_one;
            end
            if (w_fail && (fail_cnt != '1)) begin
                fail_cnt <= fail_cnt + c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_until_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_until_checker
// Description : Self-checking bench for until_checker. Four instances share
//               p/q/eot/rst and have private start lines:
//               0 weak, 1 strong, 2 weak with MAX_WAIT=8, 3 weak with CNT_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_until_checker;

    typedef struct {
        int         inst;
        logic       is_pass;
        logic [1:0] code;
        int         wcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p   = 1'b0;
    logic        q   = 1'b0;
    logic        eot = 1'b0;
    logic [3:0]  st  = 4'b0000;

    logic        busy [4];
    logic        pass [4];
    logic        fail [4];
    logic [1:0]  code [4];
    logic [15:0] wcnt [4];
    logic [15:0] pcnt [4];
    logic [15:0] fcnt [4];
    logic [3:0]  wc3, pc3, fc3;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    until_checker #(.STRONG(0), .CNT_W(16), .MAX_WAIT(0)) u_weak (
        .clk(clk), .rst(rst), .start(st[0]), .p(p), .q(q), .eot(eot),
        .busy(busy[0]), .pass(pass[0]), .fail(fail[0]), .fail_code(code[0]),
        .wait_cnt(wcnt[0]), .pass_cnt(pcnt[0]), .fail_cnt(fcnt[0]));

    until_checker #(.STRONG(1), .CNT_W(16), .MAX_WAIT(0)) u_strong (
        .clk(clk), .rst(rst), .start(st[1]), .p(p), .q(q), .eot(eot),
        .busy(busy[1]), .pass(pass[1]), .fail(fail[1]), .fail_code(code[1]),
        .wait_cnt(wcnt[1]), .pass_cnt(pcnt[1]), .fail_cnt(fcnt[1]));

    until_checker #(.STRONG(0), .CNT_W(16), .MAX_WAIT(8)) u_tmo (
        .clk(clk), .rst(rst), .start(st[2]), .p(p), .q(q), .eot(eot),
        .busy(busy[2]), .pass(pass[2]), .fail(fail[2]), .fail_code(code[2]),
        .wait_cnt(wcnt[2]), .pass_cnt(pcnt[2]), .fail_cnt(fcnt[2]));

    until_checker #(.STRONG(0), .CNT_W(4), .MAX_WAIT(0)) u_sat (
        .clk(clk), .rst(rst), .start(st[3]), .p(p), .q(q), .eot(eot),
        .busy(busy[3]), .pass(pass[3]), .fail(fail[3]), .fail_code(code[3]),
        .wait_cnt(wc3), .pass_cnt(pc3), .fail_cnt(fc3));

    assign wcnt[3] = {12'd0, wc3};
    assign pcnt[3] = {12'd0, pc3};
    assign fcnt[3] = {12'd0, fc3};

    // Apply inputs, then return 1ns after the next rising edge.
    task automatic tick(input logic [3:0] s, input logic pp, input logic qq, input logic ee);
        st  = s;
        p   = pp;
        q   = qq;
        eot = ee;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic expect_res(input int i, input logic ps, input logic [1:0] c, input int w);
        exp_t e;
        e.inst    = i;
        e.is_pass = ps;
        e.code    = c;
        e.wcnt    = w;
        sb.push_back(e);
    endtask

    // Scoreboard: every verdict pulse must match the oldest expectation of its instance.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (pass[i] || fail[i]) begin
                    int         k;
                    logic [3:0] got;
                    logic [3:0] want;
                    k = -1;
                    for (int j = 0; j < sb.size(); j++)
                        if (k < 0 && sb[j].inst == i) k = j;
                    n_cmp++;
                    if (k < 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected inst%0d t=%0t: got pass=%0b fail=%0b code=%0b, required no pulse",
                                 i, $time, pass[i], fail[i], code[i]);
                    end else begin
                        got  = {pass[i], fail[i], code[i]};
                        want = {sb[k].is_pass, !sb[k].is_pass, sb[k].is_pass ? 2'b00 : sb[k].code};
                        if (got !== want || wcnt[i] !== 16'(sb[k].wcnt)) begin
                            n_err++;
                            $display("FAIL sb_verdict inst%0d t=%0t: got pass/fail/code=%b wait=%0d, required %b wait=%0d",
                                     i, $time, got, wcnt[i], want, sb[k].wcnt);
                        end
                        sb.delete(k);
                    end
                end else begin
                    n_cmp++;
                    if (code[i] !== 2'b00) begin
                        n_err++;
                        $display("FAIL code_idle inst%0d t=%0t: got %b, required 00", i, $time, code[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(4'b1111, 1'b1, 1'b1, 1'b1);
        tick(4'b1111, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({busy[i], pass[i], fail[i], code[i]} !== 5'b0 || wcnt[i] !== 16'd0 ||
                pcnt[i] !== 16'd0 || fcnt[i] !== 16'd0) begin
                n_err++;
                $display("FAIL reset inst%0d: got busy=%0b pass=%0b fail=%0b code=%b w=%0d pc=%0d fc=%0d, required all 0",
                         i, busy[i], pass[i], fail[i], code[i], wcnt[i], pcnt[i], fcnt[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_weak_strong_eot();
        do_reset();
        expect_res(0, 1'b1, 2'b00, 20);
        expect_res(1, 1'b0, 2'b10, 20);
        tick(4'b0011, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (busy[0] !== 1'b1 || busy[1] !== 1'b1) begin
            n_err++;
            $display("FAIL eot_busy: got %0b/%0b, required 1/1", busy[0], busy[1]);
        end
        repeat (19) tick(4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (pass[0] !== 1'b1 || fail[0] !== 1'b0 || pcnt[0] !== 16'd1 || fcnt[0] !== 16'd0 ||
            wcnt[0] !== 16'd20 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL eot_weak: got pass=%0b fail=%0b pc=%0d fc=%0d w=%0d busy=%0b, required 1 0 1 0 20 0",
                     pass[0], fail[0], pcnt[0], fcnt[0], wcnt[0], busy[0]);
        end
        n_cmp++;
        if (fail[1] !== 1'b1 || pass[1] !== 1'b0 || code[1] !== 2'b10 || fcnt[1] !== 16'd1 ||
            pcnt[1] !== 16'd0 || wcnt[1] !== 16'd20) begin
            n_err++;
            $display("FAIL eot_strong: got fail=%0b pass=%0b code=%b fc=%0d pc=%0d w=%0d, required 1 0 10 1 0 20",
                     fail[1], pass[1], code[1], fcnt[1], pcnt[1], wcnt[1]);
        end
        n_cmp++;
        if (pcnt[2] !== 16'd0 || fcnt[2] !== 16'd0) begin
            n_err++;
            $display("FAIL eot_idle: got pc=%0d fc=%0d, required 0 0", pcnt[2], fcnt[2]);
        end
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (pass[0] !== 1'b0 || fail[1] !== 1'b0) begin
            n_err++;
            $display("FAIL eot_pulse_width: got pass=%0b fail=%0b, required 0 0", pass[0], fail[1]);
        end
    endtask

    task automatic test_immediate_pass();
        do_reset();
        expect_res(0, 1'b1, 2'b00, 0);
        expect_res(1, 1'b1, 2'b00, 0);
        tick(4'b0011, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (pass[0] !== 1'b1 || pass[1] !== 1'b1 || busy[0] !== 1'b0 || busy[1] !== 1'b0 ||
            wcnt[0] !== 16'd0) begin
            n_err++;
            $display("FAIL immediate: got pass=%0b/%0b busy=%0b/%0b w=%0d, required 1/1 0/0 0",
                     pass[0], pass[1], busy[0], busy[1], wcnt[0]);
        end
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (busy[0] !== 1'b0 || pass[0] !== 1'b0) begin
            n_err++;
            $display("FAIL immediate_after: got busy=%0b pass=%0b, required 0 0", busy[0], pass[0]);
        end
    endtask

    task automatic test_p_drop();
        do_reset();
        expect_res(0, 1'b0, 2'b01, 5);
        tick(4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (4) tick(4'b0000, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (busy[0] !== 1'b1 || wcnt[0] !== 16'd5) begin
            n_err++;
            $display("FAIL pdrop_wait: got busy=%0b w=%0d, required 1 5", busy[0], wcnt[0]);
        end
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (fail[0] !== 1'b1 || code[0] !== 2'b01 || wcnt[0] !== 16'd5 || fcnt[0] !== 16'd1) begin
            n_err++;
            $display("FAIL pdrop: got fail=%0b code=%b w=%0d fc=%0d, required 1 01 5 1",
                     fail[0], code[0], wcnt[0], fcnt[0]);
        end
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        do_reset();
        expect_res(2, 1'b0, 2'b11, 7);
        tick(4'b0100, 1'b1, 1'b0, 1'b0);
        repeat (6) tick(4'b0000, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (fail[2] !== 1'b0 || busy[2] !== 1'b1 || wcnt[2] !== 16'd7) begin
            n_err++;
            $display("FAIL timeout_early: got fail=%0b busy=%0b w=%0d, required 0 1 7", fail[2], busy[2], wcnt[2]);
        end
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (fail[2] !== 1'b1 || code[2] !== 2'b11 || busy[2] !== 1'b0) begin
            n_err++;
            $display("FAIL timeout: got fail=%0b code=%b busy=%0b, required 1 11 0", fail[2], code[2], busy[2]);
        end
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_q_eot_strong();
        do_reset();
        expect_res(1, 1'b1, 2'b00, 3);
        tick(4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (2) tick(4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (pass[1] !== 1'b1 || fail[1] !== 1'b0 || pcnt[1] !== 16'd1 || fcnt[1] !== 16'd0) begin
            n_err++;
            $display("FAIL q_eot_strong: got pass=%0b fail=%0b pc=%0d fc=%0d, required 1 0 1 0",
                     pass[1], fail[1], pcnt[1], fcnt[1]);
        end
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        do_reset();
        expect_res(0, 1'b1, 2'b00, 0);
        tick(4'b0001, 1'b0, 1'b1, 1'b0);
        tick(4'b0011, 1'b1, 1'b0, 1'b0);
        repeat (2) tick(4'b0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick(4'b0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        n_cmp++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0 || pass[0] !== 1'b0 || fail[1] !== 1'b0 ||
            wcnt[0] !== 16'd0 || pcnt[0] !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset: got busy=%0b/%0b pass=%0b fail=%0b w=%0d pc=%0d, required all 0",
                     busy[0], busy[1], pass[0], fail[1], wcnt[0], pcnt[0]);
        end
        repeat (3) tick(4'b0000, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (busy[0] !== 1'b0 || fcnt[1] !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset_after: got busy=%0b fc=%0d, required 0 0", busy[0], fcnt[1]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        expect_res(0, 1'b1, 2'b00, 5);
        expect_res(0, 1'b1, 2'b00, 0);
        tick(4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (4) tick(4'b0001, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (busy[0] !== 1'b1 || wcnt[0] !== 16'd5) begin
            n_err++;
            $display("FAIL b2b_busy: got busy=%0b w=%0d, required 1 5", busy[0], wcnt[0]);
        end
        tick(4'b0001, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (pass[0] !== 1'b1 || busy[0] !== 1'b0 || wcnt[0] !== 16'd5) begin
            n_err++;
            $display("FAIL b2b_resolve: got pass=%0b busy=%0b w=%0d, required 1 0 5", pass[0], busy[0], wcnt[0]);
        end
        tick(4'b0001, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (pass[0] !== 1'b1 || wcnt[0] !== 16'd0 || pcnt[0] !== 16'd2) begin
            n_err++;
            $display("FAIL b2b_restart: got pass=%0b w=%0d pc=%0d, required 1 0 2", pass[0], wcnt[0], pcnt[0]);
        end
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (pass[0] !== 1'b0 || pcnt[0] !== 16'd2 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: got pass=%0b pc=%0d busy=%0b, required 0 2 0", pass[0], pcnt[0], busy[0]);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < 18; n++) begin
            expect_res(3, 1'b1, 2'b00, 0);
            expect_res(0, 1'b1, 2'b00, 0);
        end
        for (int n = 0; n < 18; n++) begin
            tick(4'b1001, 1'b0, 1'b1, 1'b0);
            if (n == 14) begin
                n_cmp++;
                if (pcnt[3] !== 16'd15) begin
                    n_err++;
                    $display("FAIL sat_reach: got pc=%0d, required 15", pcnt[3]);
                end
            end
        end
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (pcnt[3] !== 16'd15 || fcnt[3] !== 16'd0 || pcnt[0] !== 16'd18) begin
            n_err++;
            $display("FAIL sat_hold: got pc4=%0d fc4=%0d pc16=%0d, required 15 0 18", pcnt[3], fcnt[3], pcnt[0]);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_weak_strong_eot();
        test_immediate_pass();
        test_p_drop();
        test_timeout();
        test_q_eot_strong();
        test_mid_reset();
        test_back_to_back();
        test_saturation();
        tick(4'b0000, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d unresolved expectations, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/until_checker.md
Name: until_checker

Overview:
- Synthesizable run-time checker for the temporal property "p until q" (weak) or "p s_until q" (strong). Selected by parameter.
- Sits directly downstream of the signals under test, e.g. a reset line (p) and its release condition (q). Mirrors the simulator's assertion semantics in hardware so FPGA builds and emulation get pass/fail pulses and counters.
- One attempt at a time, launched by `start`.
- An end-of-observation strobe `eot` resolves still-pending attempts: pass in weak mode, fail in strong mode.

Parameters:
- STRONG, 0, 0 = weak until (pending at eot passes); 1 = s_until (pending at eot fails).
- CNT_W, 16, width of wait_cnt, pass_cnt and fail_cnt.
- MAX_WAIT, 0, 0 = unbounded wait; N>0 = fail with timeout if q has not arrived after N cycles of waiting.

Ports:
- clk  in  1  clock; all sampling on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch an attempt on this edge; ignored while busy.
- p  in  1  hold condition; must be 1 on every edge of the attempt until q.
- q  in  1  release condition.
- eot  in  1  end-of-observation strobe; resolves a pending attempt.
- busy  out  1  attempt pending (state WAIT).
- pass  out  1  one-cycle pass pulse.
- fail  out  1  one-cycle fail pulse.
- fail_code  out  2  valid with fail: 01 p dropped before q, 10 strong pending at eot, 11 MAX_WAIT timeout; 00 otherwise.
- wait_cnt  out  CNT_W  edges evaluated in the current/last attempt with p=1 and q=0.
- pass_cnt  out  CNT_W  saturating count of passes.
- fail_cnt  out  CNT_W  saturating count of fails.

Behaviour:
- Reset: on any edge with rst=1 → state IDLE; busy, pass, fail, fail_code, wait_cnt, pass_cnt and fail_cnt all 0. rst overrides every other input.
- Reset mid-attempt: the attempt is aborted silently (no pass/fail pulse) and the counters clear.
- States: IDLE, WAIT.
- Evaluation edge: the edge with start=1 in IDLE, and every edge while in WAIT. The same rule applies on each evaluation edge, in priority order:
  1. q=1 → pass; q at the start edge passes immediately and p is not required on that edge.
  2. else p=0 → fail, code 01.
  3. else eot=1 → pass if STRONG=0; fail code 10 if STRONG=1.
  4. else MAX_WAIT>0 and wait_cnt+1 == MAX_WAIT → fail, code 11.
  5. else → wait_cnt increments; state is WAIT.
- wait_cnt clears to 0 on each start accepted in IDLE. It is held after the attempt resolves, until the next start.
- Any resolution returns the FSM to IDLE.
- Output timing: pass/fail/fail_code are registered. They assert in the cycle after the deciding edge, for exactly one cycle. pass and fail are never high together.
- busy is high from the cycle after an accepted start until the cycle after resolution. busy is 0 when the attempt resolves on its start edge.
- start while busy: ignored, no effect.
- start on a resolution edge in WAIT: ignored. A new attempt can start at the earliest on the next edge, when the FSM is in IDLE.
- eot in IDLE without start: no effect.
- pass_cnt and fail_cnt increment on the same edge the pulse is registered. Both saturate at all-ones.

Test Plan:
- STRONG=0: start=1 at cycle 1; p=1 and q=0 held 20 cycles; eot at cycle 21 → pass pulse in cycle 22, fail never, wait_cnt=20, pass_cnt=1.
- STRONG=1, same stimulus → fail in cycle 22, fail_code=10, fail_cnt=1, pass_cnt=0.
- start with q=1 and p=0 on the same edge → pass next cycle, busy never high, wait_cnt=0.
- p=1 for 5 waiting edges, then p=0 with q=0 → fail, fail_code=01, wait_cnt=5.
- MAX_WAIT=8, p=1, q never → fail on the 8th evaluation edge, fail_code=11.
- Same edge q=1 and eot=1 with STRONG=1 → pass.
- rst pulsed at wait cycle 3 → no pulse, busy=0, counters 0.
- start pulses while busy → ignored, only one resolution.
- 2^CNT_W+2 passes with CNT_W=4 → pass_cnt holds 15.
